// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - frame-synchronous hobby-servo PWM driver with bounded position register
module servo_pwm_driver #(
  parameter int FRAME_CYCLES = 500000,
  parameter int MIN_POS      = 25000,
  parameter int MAX_POS      = 50000,
  parameter int HOME_POS     = 37500,
  parameter int STEP         = 250,
  parameter int MODE         = 0,
  parameter int REST_POS     = 37500,
  parameter int FIRE_POS     = 50000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [3:0]  i_Angle_Cmd,
  output logic        o_Servo_PWM,
  output logic [15:0] o_Position,
  output logic        o_At_Min,
  output logic        o_At_Max,
  output logic        o_Frame_Start
);

  localparam int CW = 19;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [16:0] MIN17  = 17'(MIN_POS);
  localparam logic [16:0] MAX17  = 17'(MAX_POS);
  localparam logic [16:0] STEP17 = 17'(STEP);
  localparam logic [16:0] REST17 = 17'(REST_POS);
  localparam logic [16:0] FIRE17 = 17'(FIRE_POS);
  localparam logic [15:0] HOME16 = 16'(HOME_POS);
  localparam logic [15:0] MIN16  = 16'(MIN_POS);
  localparam logic [15:0] MAX16  = 16'(MAX_POS);

  logic [CW-1:0] cnt;
  logic [3:0]    cmd_q;
  logic [15:0]   pos;
  logic [15:0]   width_q;
  logic [15:0]   next_pos;
  logic          boundary;

  logic [16:0] pos17;
  logic [16:0] up;
  logic [16:0] dn;
  logic [16:0] tgt;
  logic [16:0] nxt17;

  assign boundary   = (cnt == CNT_LAST);
  assign o_Position = pos;

  // All position math is done at 17 bits so clamping never sees a wrapped value.
  always_comb begin
    pos17 = {1'b0, pos};
    up    = (pos17 + STEP17 > MAX17) ? MAX17 : pos17 + STEP17;
    dn    = (pos17 >= MIN17 + STEP17) ? pos17 - STEP17 : MIN17;
    tgt   = pos17;
    nxt17 = pos17;
    if (MODE == 0) begin
      case (cmd_q)
        4'd1:    nxt17 = dn;
        4'd2:    nxt17 = up;
        default: nxt17 = pos17;
      endcase
    end else begin
      case (cmd_q)
        4'd1:       tgt = FIRE17;
        4'd0, 4'd2: tgt = REST17;
        default:    tgt = pos17;
      endcase
      if (tgt < MIN17) tgt = MIN17;
      if (tgt > MAX17) tgt = MAX17;
      if (tgt > pos17)
        nxt17 = (tgt - pos17 <= STEP17) ? tgt : pos17 + STEP17;
      else if (tgt < pos17)
        nxt17 = (pos17 - tgt <= STEP17) ? tgt : pos17 - STEP17;
      else
        nxt17 = pos17;
    end
    next_pos = nxt17[15:0];
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt           <= '0;
      cmd_q         <= '0;
      pos           <= HOME16;
      width_q       <= HOME16;
      o_Servo_PWM   <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_At_Min      <= (HOME_POS == MIN_POS);
      o_At_Max      <= (HOME_POS == MAX_POS);
    end else begin
      cmd_q         <= i_Angle_Cmd;
      o_Frame_Start <= boundary;
      // Pulse covers counts 1..width so it rises on the 2nd edge of a frame.
      o_Servo_PWM   <= (cnt != '0) && (cnt <= {{(CW-16){1'b0}}, width_q});
      if (boundary) begin
        cnt      <= '0;
        pos      <= next_pos;
        width_q  <= next_pos;
        o_At_Min <= (next_pos == MIN16);
        o_At_Max <= (next_pos == MAX16);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/servo_pwm_driver.md
# servo_pwm_driver

Consumes the 4-bit angle command codes produced by the switch/fire command FSMs (x, y, fire channels) and turns them into a standard hobby-servo PWM waveform, one instance per servo. Each instance holds a bounded pulse-width position register. Once per 20 ms frame, it either steps that register (incremental mode, x/y axes) or slews it toward a fixed target (absolute mode, fire servo). It sits between the command FSMs and the Go Board servo output pins.

## Interface
- FRAME_CYCLES, 500000: clocks per PWM frame (20 ms at 25 MHz); must be ≤ 2^19.
- MIN_POS, 25000: minimum pulse width in clocks (1 ms).
- MAX_POS, 50000: maximum pulse width in clocks (2 ms); MIN_POS < MAX_POS < 65536, MAX_POS < FRAME_CYCLES.
- HOME_POS, 37500: position after reset; MIN_POS ≤ HOME_POS ≤ MAX_POS.
- STEP, 250: position change per frame; 1 ≤ STEP ≤ MAX_POS − MIN_POS.
- MODE, 0: 0 = incremental (x/y axis), 1 = absolute (fire servo).
- REST_POS, 37500: MODE=1 target for codes 0 and 2.
- FIRE_POS, 50000: MODE=1 target for code 1.
- i_Clk  in  1  system clock, all logic on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Angle_Cmd  in  4  command code from the angle FSM (same clock domain).
- o_Servo_PWM  out  1  servo pulse; high for the current frame's width.
- o_Position  out  16  current position register (clocks).
- o_At_Min  out  1  high while o_Position == MIN_POS.
- o_At_Max  out  1  high while o_Position == MAX_POS.
- o_Frame_Start  out  1  one-cycle pulse marking each frame boundary.

## Operation
- Command register: cmd_q <= i_Angle_Cmd every cycle.
- Frame counter cnt: counts 0..FRAME_CYCLES−1, then wraps to 0. The edge that takes cnt from FRAME_CYCLES−1 to 0 is the frame boundary.
- Position updates only at a frame boundary, using cmd_q at that edge. This keeps pulses glitch-free.
- At the same edge, width_q <= the new position and o_Frame_Start <= 1. o_Frame_Start is 0 on all other cycles.
- MODE=0 updates:
  - code 1: pos <= max(pos − STEP, MIN_POS).
  - code 2: pos <= min(pos + STEP, MAX_POS).
  - codes 0, 5 and all others: hold.
  - Arithmetic must be done at 17 bits (or compare-before-subtract) so there is no wrap-around below 0 or above 65535.
- MODE=1 updates:
  - Target selection: code 1 → FIRE_POS; codes 0 and 2 → REST_POS; other codes → target = pos (hold).
  - Target is clamped to [MIN_POS, MAX_POS].
  - If |target − pos| ≤ STEP, pos <= target; otherwise pos moves by STEP toward target.
- PWM: o_Servo_PWM is registered. It is high for exactly width_q consecutive cycles, starting the cycle after the boundary edge, then low for the rest of the frame.
- o_At_Min and o_At_Max are registered compares of the position register, updated in the same edge as the position.

## Timing
- Reset values (asynchronous, take effect immediately on i_Rst_n low, including mid-pulse):
  - cnt = 0, cmd_q = 0.
  - pos = width_q = HOME_POS.
  - o_Servo_PWM = 0, o_Frame_Start = 0.
  - o_At_Min = (HOME_POS == MIN_POS), o_At_Max = (HOME_POS == MAX_POS).
- First frame after reset release:
  - o_Servo_PWM goes high on the 2nd rising edge after release.
  - It stays high for HOME_POS cycles.
  - The first o_Frame_Start occurs FRAME_CYCLES cycles after the first counting edge.
- Command latency: a code on i_Angle_Cmd must be stable during the last two cycles of a frame to take effect at that boundary. Codes that change mid-frame and revert have no effect.
- Position and width change at most once per frame; the pulse period is always exactly FRAME_CYCLES.
- Boundary conditions:
  - Clamping at MIN/MAX holds the position; it never overshoots or wraps.
  - If pos is already at target (MODE=1), it holds.
  - If the reset edge coincides with a frame boundary, reset wins.

## Test plan
All scenarios use FRAME_CYCLES=100, MIN_POS=10, MAX_POS=30, HOME_POS=20, STEP=4.

- Reset release, cmd=0 held → o_Servo_PWM high 20 cycles per 100-cycle frame; o_Frame_Start pulses once per 100 cycles; o_Position=20, At_Min=At_Max=0.
- MODE=0, cmd=2 held 5 frames → widths 24, 28, 30, 30; o_At_Max asserts with position 30 and stays asserted.
- MODE=0, cmd=1 held from 20 → widths 16, 12, 10, 10; o_At_Min asserts at 10. Then cmd=5 or 3..15 → width stays 10.
- MODE=0, cmd=2 pulsed only for cycles 40–60 of a frame → no position change at the following boundary.
- MODE=1 (REST_POS=20, FIRE_POS=30): cmd=1 → widths 24, 28, 30; then cmd=2 → 26, 22, 20; then cmd=0 → holds 20.
- Assert i_Rst_n low mid-pulse at position 28 → o_Servo_PWM drops to 0 immediately. After release, width is 20 and frame timing restarts from cnt=0.
